fifo_stream_reader: RTL and testbench

- Read-side consumer for the synchronous FIFO: pops words through the FIFO read port and presents them as a valid/ready stream.
- Hides the FIFO's 1-cycle read latency with a small skid buffer, so a continuously-ready sink gets 1 word/cycle.
- Adds a flush operation that discards all buffered, in-flight and FIFO-resident data.
- Sits between the FIFO and any downstream consumer, mirroring the writer-side stimulus.

---
 rtl/fifo_stream_reader_pkg.sv | 27 ++
 rtl/fifo_stream_reader_if.sv | 32 +++
 rtl/fifo_stream_reader_skid_buffer.sv | 84 ++++++++
 rtl/fifo_stream_reader.sv | 115 +++++++++++
 tb/tb_fifo_stream_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_reader_pkg
// Shared definitions for the FIFO stream reader:
//   - rd_state_e : reader control states (RUN / FLUSH / DONE)
//   - DEFAULT_*  : default widths and depths
//   - credit_ok  : decides whether another FIFO pop may be issued without
//                  overrunning the skid buffer
package fifo_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_SKID_DEPTH = 2;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } rd_state_e;

  // A new pop is safe when every word already owed to the buffer (stored
  // plus in flight, minus the one leaving this cycle) still leaves a free
  // slot for the word this pop will return next cycle.
  function automatic logic credit_ok(input int occupancy, input int inflight,
                                     input int pop_out, input int depth);
    return (occupancy + inflight - pop_out) < depth;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
// Bundles the FIFO read port, the outgoing valid/ready stream and the flush
// controls of the reader.
//   master : the reader (drives Read_enable, stream outputs, flush status)
//   slave  : the surroundings (FIFO flags/data, sink ready, flush request)
interface fifo_stream_reader_if
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  Read_enable;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  flush;
  logic                  flush_busy;
  logic                  flush_done;
  logic [CNT_WIDTH-1:0]  word_count;

  modport master (
    input  empty, data_out, m_ready, flush,
    output Read_enable, m_valid, m_data, flush_busy, flush_done, word_count
  );

  modport slave (
    output empty, data_out, m_ready, flush,
    input  Read_enable, m_valid, m_data, flush_busy, flush_done, word_count
  );
endinterface

// File: rtl/fifo_stream_reader_skid_buffer.sv
// fifo_skid_buffer
// Small circular buffer that absorbs the words returned by the FIFO while the
// sink is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : drop all entries (pointers and occupancy to zero)
//   push       : write push_data at the tail
//   pop        : retire the head entry
//   head       : current head entry
//   occupancy  : number of stored entries (0..DEPTH)
module fifo_skid_buffer
  import fifo_reader_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_SKID_DEPTH,
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  // Explicit wrap so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

  // The credit check upstream must make these impossible.
  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clear && occ_q == OCC_W'(DEPTH)));
  underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !clear && occ_q == '0));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pops words from a synchronous FIFO (1-cycle read latency) and presents them
// as a valid/ready stream at up to one word per cycle, with a flush operation
// that discards buffered, in-flight and FIFO-resident data.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fifo_stream_reader_if.master
//           empty/data_out/Read_enable : FIFO read port
//           m_valid/m_ready/m_data     : output stream
//           flush/flush_busy/flush_done: flush request and status
//           word_count                 : stream handshakes since reset (wraps)
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SKID_DEPTH = DEFAULT_SKID_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input logic                 clk,
  input logic                 reset,
  fifo_stream_reader_if.master bus
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  rd_state_e             state_q, state_d;
  logic                  active_q;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  flush_busy_q, flush_busy_d;
  logic                  flush_done_q, flush_done_d;

  logic [OCC_W-1:0]      occupancy;
  logic [DATA_WIDTH-1:0] head;
  logic                  m_valid;
  logic                  pop_out;
  logic                  read_en;
  logic                  capture;
  logic                  clear;

  assign m_valid = (occupancy != '0) && (state_q == RUN);
  // The flush cycle never counts as a handshake, even with m_ready high.
  assign pop_out = m_valid && bus.m_ready && !bus.flush;
  assign clear   = (state_q == RUN) && bus.flush;
  // Returning words are kept only in RUN outside the flush cycle itself.
  assign capture = inflight_q && (state_q == RUN) && !bus.flush;

  // active_q keeps Read_enable low while reset is held, since the credit
  // check alone would otherwise request a pop from the reset state.
  always_comb begin
    read_en = 1'b0;
    if (active_q) begin
      case (state_q)
        RUN:     read_en = !bus.empty &&
                           credit_ok(int'(occupancy), int'(inflight_q),
                                     int'(pop_out), SKID_DEPTH);
        FLUSH:   read_en = !bus.empty;
        default: read_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    inflight_d = read_en;  // read_en already implies !empty, so it is a pop
    count_d    = count_q + CNT_WIDTH'(pop_out);
    case (state_q)
      RUN:     if (bus.flush) state_d = FLUSH;
      FLUSH:   if (bus.empty && !inflight_q) state_d = DONE;
      default: state_d = RUN;
    endcase
    flush_busy_d = (state_d == FLUSH);
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      active_q     <= 1'b0;
      inflight_q   <= 1'b0;
      count_q      <= '0;
      flush_busy_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      flush_busy_q <= flush_busy_d;
      flush_done_q <= flush_done_d;
    end
  end

  fifo_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SKID_DEPTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (clear),
    .push     (capture),
    .push_data(bus.data_out),
    .pop      (pop_out),
    .head     (head),
    .occupancy(occupancy)
  );

  assign bus.Read_enable = read_en;
  assign bus.m_valid     = m_valid;
  assign bus.m_data      = head;
  assign bus.flush_busy  = flush_busy_q;
  assign bus.flush_done  = flush_done_q;
  assign bus.word_count  = count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
module tb_fifo_stream_reader;
  import fifo_reader_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .SKID_DEPTH(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));

  // Narrow-counter copy fed with identical stimulus, used for the wrap check.
  fifo_stream_reader #(.DATA_WIDTH(DW), .SKID_DEPTH(2), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.master));

  assign bus4.empty    = bus.empty;
  assign bus4.data_out = bus.data_out;
  assign bus4.m_ready  = bus.m_ready;
  assign bus4.flush    = bus.flush;

  // FIFO contents and the reference stream: every word written and not yet
  // delivered, minus words discarded by flush or lost to reset.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_total = 0;
  int phase_hs = 0;
  int first_hs, last_hs, first_re, first_mv;
  int done_cnt, done_cyc;
  int re_empty_viol = 0;
  logic prev_stall = 1'b0;
  logic s_re, s_mv, s_busy;
  logic [DW-1:0] s_data;

  typedef struct {
    logic          m_ready;
    logic          exp_re;
    logic          exp_mv;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t bp [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    bus.empty = 1'b0;
  endtask

  // One clock cycle: sample at negedge, clock edge, then update the FIFO
  // model (its data_out/empty change just after the edge).
  task automatic step();
    logic pop_now, hs;
    @(negedge clk);
    cyc++;
    s_re   = bus.Read_enable;
    s_mv   = bus.m_valid;
    s_data = bus.m_data;
    s_busy = bus.flush_busy;
    pop_now = bus.Read_enable && !bus.empty;
    if (bus.Read_enable && bus.empty) re_empty_viol++;
    if (bus.Read_enable && first_re < 0) first_re = cyc;
    if (bus.m_valid && first_mv < 0) first_mv = cyc;
    if (bus.flush_done) begin done_cnt++; done_cyc = cyc; end
    hs = bus.m_valid && bus.m_ready && !bus.flush;
    if (reset) begin
      check("word_count", {16'd0, bus.word_count}, hs_total);
      check("word_count4", {28'd0, bus4.word_count}, hs_total % 16);
      if (hs_total == 17) check("wrap17", {28'd0, bus4.word_count}, 1);
      if (prev_stall) check("hold_valid", {31'd0, bus.m_valid}, 1);
      if (hs) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: got %0h required none (cycle %0d)", bus.m_data, cyc);
        end else begin
          check("stream_data", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
        end
        hs_total++;
        phase_hs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      prev_stall = bus.m_valid && !bus.m_ready && !bus.flush;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    if (pop_now) bus.data_out = fifo_q.pop_front();
    bus.empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    if (exp_q.size() != 0) check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_re"},    {31'd0, bus.Read_enable}, 0);
    check({tag, "_mv"},    {31'd0, bus.m_valid}, 0);
    check({tag, "_data"},  {24'd0, bus.m_data}, 0);
    check({tag, "_busy"},  {31'd0, bus.flush_busy}, 0);
    check({tag, "_done"},  {31'd0, bus.flush_done}, 0);
    check({tag, "_wc"},    {16'd0, bus.word_count}, 0);
    check({tag, "_wc4"},   {28'd0, bus4.word_count}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int written, fcyc, start;
    // Backpressure vectors: 10 stalled cycles, then m_ready held high.
    for (int i = 0; i < 10; i++) bp[i] = '{1'b0, (i < 2), (i >= 2), 8'hA0};
    bp[10] = '{1'b1, 1'b1, 1'b1, 8'hA0};
    bp[11] = '{1'b1, 1'b1, 1'b1, 8'hA1};
    bp[12] = '{1'b1, 1'b1, 1'b1, 8'hA2};
    bp[13] = '{1'b1, 1'b1, 1'b1, 8'hA3};
    bp[14] = '{1'b1, 1'b1, 1'b1, 8'hA4};
    bp[15] = '{1'b1, 1'b1, 1'b1, 8'hA5};
    bp[16] = '{1'b1, 1'b0, 1'b1, 8'hA6};
    bp[17] = '{1'b1, 1'b0, 1'b1, 8'hA7};
    bp[18] = '{1'b1, 1'b0, 1'b0, 8'h00};

    first_hs = -1; first_re = -1; first_mv = -1; done_cnt = 0; done_cyc = -1; last_hs = -1;
    reset = 1'b1;
    bus.empty = 1'b1; bus.data_out = '0; bus.m_ready = 1'b0; bus.flush = 1'b0;
    #3 reset = 1'b0;
    #9;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) step();

    // ---- backpressure (table-driven) ----
    for (int i = 0; i < 8; i++) fifo_write(8'(8'hA0 + i));
    for (int i = 0; i < 19; i++) begin
      bus.m_ready = bp[i].m_ready;
      step();
      check($sformatf("bp_re[%0d]", i), {31'd0, s_re}, {31'd0, bp[i].exp_re});
      check($sformatf("bp_mv[%0d]", i), {31'd0, s_mv}, {31'd0, bp[i].exp_mv});
      if (bp[i].exp_mv) check($sformatf("bp_data[%0d]", i), {24'd0, s_data}, {24'd0, bp[i].exp_data});
    end
    check("bp_wc", {16'd0, bus.word_count}, 8);
    check("bp_left", exp_q.size(), 0);

    // ---- throughput ----
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 32; i++) fifo_write(8'(i));
    phase_hs = 0; first_hs = -1; start = cyc + 1;
    drain("thru", 100);
    check("thru_count", phase_hs, 32);
    check("thru_back_to_back", last_hs - first_hs, 31);
    check("thru_latency", first_hs - start, 2);
    check("thru_wc", {16'd0, bus.word_count}, 40);
    check("thru_wc4", {28'd0, bus4.word_count}, 40 % 16);
    check("re_while_empty", re_empty_viol, 0);

    // ---- random m_ready and write timing ----
    phase_hs = 0; written = 0;
    for (int n = 0; n < 4000 && (written < 200 || exp_q.size() != 0); n++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if (written < 200 && $urandom_range(0, 1) == 1) begin
        fifo_write(8'($urandom));
        written++;
      end
      step();
    end
    bus.m_ready = 1'b1;
    drain("rand", 20);
    check("rand_count", phase_hs, 200);
    check("rand_wc", {16'd0, bus.word_count}, 240);
    check("rand_re_while_empty", re_empty_viol, 0);

    // ---- flush with a pop in flight ----
    repeat (3) step();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_write(8'(8'hC0 + i));
    step();                       // first pop accepted
    bus.flush = 1'b1;
    step();                       // flush cycle
    fcyc = cyc;
    bus.flush = 1'b0;
    bus.m_ready = 1'b1;
    exp_q.delete();
    done_cnt = 0; done_cyc = -1;
    step();
    check("flush_mv_next", {31'd0, s_mv}, 0);
    check("flush_busy_next", {31'd0, s_busy}, 1);
    repeat (20) step();
    check("flush_done_pulses", done_cnt, 1);
    check("flush_done_cycle", done_cyc - fcyc, 6);
    check("flush_fifo_drained", fifo_q.size(), 0);
    check("flush_busy_end", {31'd0, bus.flush_busy}, 0);
    fifo_write(8'h55);
    drain("post_flush", 20);
    check("post_flush_wc", {16'd0, bus.word_count}, 241);

    // ---- reset mid-stream ----
    repeat (2) step();
    for (int i = 0; i < 10; i++) fifo_write(8'(8'h10 + i));
    phase_hs = 0;
    for (int n = 0; n < 20 && phase_hs < 3; n++) step();
    check("pre_reset_hs", phase_hs, 3);
    reset = 1'b0;
    #2;
    check_reset_outputs("midreset");
    exp_q = fifo_q;               // words popped but undelivered are lost
    hs_total = 0;
    check("midreset_fifo_left", fifo_q.size(), 5);
    step();
    check("in_reset_re", {31'd0, s_re}, 0);
    step();
    reset = 1'b1;
    first_re = -1; first_mv = -1;
    drain("resume", 30);
    check("resume_latency", first_mv - first_re, 2);
    check("resume_wc", {16'd0, bus.word_count}, 5);
    check("final_re_while_empty", re_empty_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
